// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed little-endian byte stream (word count, payload, checksum),
// writes the payload into instruction memory and releases the CPU reset on a valid checksum.
module imem_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

  localparam logic [32:0] CAPACITY = 33'(1) << ADDR_W;

  state_t          state, state_nxt;
  logic [1:0]      byte_idx;
  logic [ADDR_W:0] word_idx;
  logic [ADDR_W:0] n_words;
  logic [7:0]      sum;
  logic [31:0]     asm_q;
  logic [31:0]     asm_nxt;
  logic            accept;
  logic            last_byte;
  logic            last_word;
  logic            n_too_big;
  logic            n_zero;

  assign rx_ready  = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
  assign busy      = rx_ready;
  assign accept    = rx_valid && rx_ready;
  // Bytes enter at the top so the first byte of a group lands in bits [7:0].
  assign asm_nxt   = {rx_data, asm_q[31:8]};
  assign last_byte = (byte_idx == 2'd3);
  assign last_word = ((word_idx + (ADDR_W+1)'(1)) == n_words);
  // The full 32-bit count is compared so large headers cannot alias into range.
  assign n_too_big = ({1'b0, asm_nxt} > CAPACITY);
  assign n_zero    = (asm_nxt == 32'd0);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= S_HDR;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case can infer a latch.
    state_nxt = state;
    case (state)
      S_HDR:  if (accept && last_byte)
                state_nxt = n_too_big ? S_ERR : (n_zero ? S_CSUM : S_DATA);
      S_DATA: if (accept && last_byte && last_word) state_nxt = S_CSUM;
      S_CSUM: if (accept) state_nxt = (rx_data == sum) ? S_DONE : S_ERR;
      S_DONE, S_ERR: if (start) state_nxt = S_HDR;
      default: state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx   <= '0;
      word_idx   <= '0;
      n_words    <= '0;
      sum        <= '0;
      asm_q      <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_HDR: if (accept) begin
          asm_q    <= asm_nxt;
          byte_idx <= byte_idx + 2'd1;
          if (last_byte) begin
            n_words <= asm_nxt[ADDR_W:0];
            if (n_too_big) err_code <= 2'b01;
          end
        end
        S_DATA: if (accept) begin
          asm_q    <= asm_nxt;
          byte_idx <= byte_idx + 2'd1;
          sum      <= sum + rx_data;
          if (last_byte) begin
            imem_we    <= 1'b1;
            imem_waddr <= word_idx[ADDR_W-1:0];
            imem_wdata <= asm_nxt;
            word_idx   <= word_idx + (ADDR_W+1)'(1);
          end
        end
        S_CSUM: if (accept) begin
          if (rx_data == sum) begin
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            err_code  <= 2'b10;
          end
        end
        S_DONE, S_ERR: if (start) begin
          cpu_reset <= 1'b1;
          done      <= 1'b0;
          err_code  <= 2'b00;
          byte_idx  <= '0;
          word_idx  <= '0;
          n_words   <= '0;
          sum       <= '0;
          asm_q     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a byte-position model of the frame format is checked against
// the DUT every cycle, plus literal expectations for the directed streams.
module tb_imem_boot_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic [1:0]        err_code;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position of the next byte within the frame decides its meaning.
  longint      m_pos, m_n;
  int          m_sum;
  logic [31:0] m_word;
  int          m_result;    // 0 loading, 1 done, 2 error
  logic [1:0]  m_err;
  logic        m_we;
  longint      m_waddr;
  logic [31:0] m_wdata;
  bit          armed = 0;

  logic [ADDR_W-1:0] cap_addr[$];
  logic [31:0]       cap_data[$];

  task automatic model_clear();
    m_pos = 0; m_n = 0; m_sum = 0; m_word = '0; m_result = 0; m_err = 2'b00;
  endtask

  task automatic model_step();
    longint k;
    m_we = 1'b0;
    if (reset) begin
      model_clear();
    end else if (m_result == 0 && rx_valid) begin
      if (m_pos < 4) begin
        m_n = m_n | (longint'(rx_data) << (8 * m_pos));
        m_pos++;
        if (m_pos == 4 && m_n > (longint'(1) << ADDR_W)) begin
          m_result = 2; m_err = 2'b01;
        end
      end else if (m_pos < 4 + 4 * m_n) begin
        k = m_pos - 4;
        m_word = m_word | (32'(rx_data) << (8 * (k % 4)));
        m_sum = m_sum + int'(rx_data);
        m_pos++;
        if (k % 4 == 3) begin
          m_we = 1'b1; m_waddr = k / 4; m_wdata = m_word; m_word = '0;
        end
      end else begin
        if (int'(rx_data) == (m_sum % 256)) m_result = 1;
        else begin m_result = 2; m_err = 2'b10; end
      end
    end else if (m_result != 0 && start) begin
      model_clear();
    end
  endtask

  initial begin
    model_clear();
    m_we = 1'b0; m_waddr = 0; m_wdata = '0;
    forever begin
      @(negedge clk);
      if (armed) begin
        check("rx_ready", 64'(rx_ready), 64'(m_result == 0));
        check("busy", 64'(busy), 64'(m_result == 0));
        check("cpu_reset", 64'(cpu_reset), 64'(m_result != 1));
        check("done", 64'(done), 64'(m_result == 1));
        check("err_code", 64'(err_code), 64'(m_err));
        check("imem_we", 64'(imem_we), 64'(m_we));
        if (m_we) begin
          check("imem_waddr", 64'(imem_waddr), 64'(m_waddr));
          check("imem_wdata", 64'(imem_wdata), 64'(m_wdata));
        end
        if (imem_we === 1'b1) begin
          cap_addr.push_back(imem_waddr);
          cap_data.push_back(imem_wdata);
        end
      end
      model_step();
      if (reset) armed = 1;
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (gap) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] q[$], input int gap_max);
    foreach (q[i]) send_byte(q[i], gap_max);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_capture();
    cap_addr.delete();
    cap_data.delete();
  endtask

  logic [7:0] good_q[$];
  logic [7:0] bad_q[$];
  logic [7:0] q[$];

  initial begin
    good_q = '{8'h02, 8'h00, 8'h00, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    bad_q  = good_q;
    bad_q[12] = 8'hB7;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst done", 64'(done), 64'd0);
    check("rst err_code", 64'(err_code), 64'd0);
    check("rst imem_we", 64'(imem_we), 64'd0);
    check("rst imem_waddr", 64'(imem_waddr), 64'd0);
    check("rst imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst busy", 64'(busy), 64'd1);

    // Two-word load with a correct checksum.
    clear_capture();
    send_list(good_q, 0);
    check("t1 writes", 64'(cap_addr.size()), 64'd2);
    check("t1 addr0", 64'(cap_addr[0]), 64'd0);
    check("t1 data0", 64'(cap_data[0]), 64'h0000_0013);
    check("t1 addr1", 64'(cap_addr[1]), 64'd1);
    check("t1 data1", 64'(cap_data[1]), 64'h0010_0093);
    check("t1 done", 64'(done), 64'd1);
    check("t1 cpu_reset", 64'(cpu_reset), 64'd0);
    check("t1 err_code", 64'(err_code), 64'd0);
    check("t1 rx_ready", 64'(rx_ready), 64'd0);

    // Bad checksum, then reload.
    pulse_start();
    check("t2 restart busy", 64'(busy), 64'd1);
    check("t2 restart done", 64'(done), 64'd0);
    check("t2 restart cpu_reset", 64'(cpu_reset), 64'd1);
    clear_capture();
    send_list(bad_q, 0);
    check("t2 writes", 64'(cap_addr.size()), 64'd2);
    check("t2 err_code", 64'(err_code), 64'd2);
    check("t2 cpu_reset", 64'(cpu_reset), 64'd1);
    check("t2 done", 64'(done), 64'd0);
    pulse_start();
    check("t2 clr err_code", 64'(err_code), 64'd0);
    send_list(good_q, 0);
    check("t2 reload done", 64'(done), 64'd1);

    // Oversized header.
    pulse_start();
    clear_capture();
    q = '{8'h01, 8'h04, 8'h00, 8'h00};
    send_list(q, 0);
    check("t3 err_code", 64'(err_code), 64'd1);
    check("t3 writes", 64'(cap_addr.size()), 64'd0);
    check("t3 cpu_reset", 64'(cpu_reset), 64'd1);

    // Empty image.
    pulse_start();
    clear_capture();
    q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_list(q, 0);
    check("t4 n0 done", 64'(done), 64'd1);
    check("t4 n0 writes", 64'(cap_addr.size()), 64'd0);

    // Full capacity: payload byte i is i[7:0]; the byte sum is a multiple of 256.
    pulse_start();
    clear_capture();
    send_byte(8'h00, 0); send_byte(8'h04, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 4096; i++) send_byte(8'(i), 0);
    send_byte(8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    check("t4 full writes", 64'(cap_addr.size()), 64'd1024);
    check("t4 last addr", 64'(cap_addr[$]), 64'd1023);
    check("t4 last data", 64'(cap_data[$]), 64'hFFFE_FDFC);
    check("t4 full done", 64'(done), 64'd1);

    // Random gaps, start held high while loading (must be ignored).
    pulse_start();
    clear_capture();
    start = 1'b1;
    foreach (good_q[i]) send_byte(good_q[i], 5);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t5 writes", 64'(cap_addr.size()), 64'd2);
    check("t5 data1", 64'(cap_data[1]), 64'h0010_0093);
    check("t5 done", 64'(done), 64'd1);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    check("t5 done rx_ready", 64'(rx_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("t5 done held", 64'(done), 64'd1);
    check("t5 cpu_reset held", 64'(cpu_reset), 64'd0);

    // Abort mid-payload with reset; byte offered during reset is dropped.
    pulse_start();
    clear_capture();
    for (int i = 0; i < 10; i++) send_byte(good_q[i], 0);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    @(posedge clk); #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    check("t6 cpu_reset", 64'(cpu_reset), 64'd1);
    check("t6 imem_we", 64'(imem_we), 64'd0);
    check("t6 busy", 64'(busy), 64'd1);
    check("t6 writes", 64'(cap_addr.size()), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("t6 no late we", 64'(cap_addr.size()), 64'd1);
    send_list(good_q, 0);
    check("t6 done", 64'(done), 64'd1);
    check("t6 total writes", 64'(cap_addr.size()), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
